md_issue_ctrl: RTL and testbench

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

---
 rtl/md_pkg.sv | 101 ++++++++++
 rtl/md_lat_counter.sv | 41 ++++
 rtl/md_issue_ctrl.sv | 89 ++++++++
 tb/tb_md_issue_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
//==============================================================================
// md_pkg : MD-op class encodings, output select constants, FSM state encoding
// Optional feature macro: MD_MADD_EN (MADD/MSUB family becomes start-class)
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package md_pkg;

   typedef logic [3:0] md_op_t;

   localparam md_op_t MD_NONE  = 4'd0;
   localparam md_op_t MD_MULT  = 4'd1;
   localparam md_op_t MD_MULTU = 4'd2;
   localparam md_op_t MD_DIV   = 4'd3;
   localparam md_op_t MD_DIVU  = 4'd4;
   localparam md_op_t MD_MADD  = 4'd5;
   localparam md_op_t MD_MADDU = 4'd6;
   localparam md_op_t MD_MSUB  = 4'd7;
   localparam md_op_t MD_MSUBU = 4'd8;
   localparam md_op_t MD_MTHI  = 4'd9;
   localparam md_op_t MD_MTLO  = 4'd10;
   localparam md_op_t MD_MFHI  = 4'd11;
   localparam md_op_t MD_MFLO  = 4'd12;

   localparam logic [2:0] MD_SEL_NONE = 3'd0;
   localparam logic [2:0] MD_SEL_MULT = 3'd1;
   localparam logic [2:0] MD_SEL_DIV  = 3'd2;
   localparam logic [2:0] MD_SEL_MADD = 3'd3;
   localparam logic [2:0] MD_SEL_MSUB = 3'd4;

   localparam logic [1:0] MD_WR_NONE = 2'd0;
   localparam logic [1:0] MD_WR_HI   = 2'd1;
   localparam logic [1:0] MD_WR_LO   = 2'd2;

   localparam logic [1:0] MD_LD_NONE = 2'd0;
   localparam logic [1:0] MD_LD_HI   = 2'd1;
   localparam logic [1:0] MD_LD_LO   = 2'd2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   function automatic logic md_is_start(input md_op_t op);
`ifdef MD_MADD_EN
      return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
                        MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
`else
      return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
`endif
   endfunction

   function automatic logic md_is_div(input md_op_t op);
      return op inside {MD_DIV, MD_DIVU};
   endfunction

   function automatic logic md_is_mt(input md_op_t op);
      return op inside {MD_MTHI, MD_MTLO};
   endfunction

   function automatic logic md_is_mf(input md_op_t op);
      return op inside {MD_MFHI, MD_MFLO};
   endfunction

   function automatic logic md_is_md(input md_op_t op);
      return md_is_start(op) || md_is_mt(op) || md_is_mf(op);
   endfunction

   function automatic logic [2:0] md_sel_of(input md_op_t op);
      case (op)
         MD_MULT, MD_MULTU: return MD_SEL_MULT;
         MD_DIV, MD_DIVU:   return MD_SEL_DIV;
         MD_MADD, MD_MADDU: return MD_SEL_MADD;
         MD_MSUB, MD_MSUBU: return MD_SEL_MSUB;
         default:           return MD_SEL_NONE;
      endcase
   endfunction

   function automatic logic md_u_of(input md_op_t op);
      return op inside {MD_MULTU, MD_DIVU, MD_MADDU, MD_MSUBU};
   endfunction

   function automatic logic [1:0] md_write_of(input md_op_t op);
      case (op)
         MD_MTHI: return MD_WR_HI;
         MD_MTLO: return MD_WR_LO;
         default: return MD_WR_NONE;
      endcase
   endfunction

   function automatic logic [1:0] md_load_of(input md_op_t op);
      case (op)
         MD_MFHI: return MD_LD_HI;
         MD_MFLO: return MD_LD_LO;
         default: return MD_LD_NONE;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/md_lat_counter.sv
//==============================================================================
// md_lat_counter : 4-bit loadable down-counter with is_one flag
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module md_lat_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic [3:0] cnt,
   output logic       is_one
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt    = cnt_q;
   assign is_one = (cnt_q == 4'd1);

endmodule

`default_nettype wire

// File: rtl/md_issue_ctrl.sv
//==============================================================================
// md_issue_ctrl : issue/stall control for the multiply/divide unit
// Optional feature macro: MD_MADD_EN (enables MADD/MSUB family issue)
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module md_issue_ctrl
   import md_pkg::*;
#(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] d_md_op,
   input  logic [3:0] e_md_op,
   input  logic       e_valid,
   input  logic       md_busy,
   output logic       md_start,
   output logic [2:0] md_sel,
   output logic       md_u,
   output logic [1:0] md_write,
   output logic [1:0] md_load,
   output logic       stall,
   output logic       md_err
);

   // The issue cycle is the first busy cycle, so BUSY holds for LAT-1 cycles.
   localparam logic [3:0] MULT_LOAD = 4'((MULT_LAT > 1) ? MULT_LAT - 1 : 1);
   localparam logic [3:0] DIV_LOAD  = 4'((DIV_LAT  > 1) ? DIV_LAT  - 1 : 1);

   logic [1:0] state_q, state_d;
   logic       err_q, err_d;
   logic       issue, e_start, e_mt;
   logic [3:0] cnt;
   logic       cnt_is_one;

   always_comb begin
      e_start  = e_valid && md_is_start(e_md_op);
      e_mt     = e_valid && md_is_mt(e_md_op);
      issue    = !reset && e_start && (state_q == ST_IDLE);

      md_start = issue;
      md_sel   = issue ? md_sel_of(e_md_op) : MD_SEL_NONE;
      md_u     = issue && md_u_of(e_md_op);
      md_write = (!reset && e_valid && (state_q == ST_IDLE)) ? md_write_of(e_md_op) : MD_WR_NONE;
      md_load  = e_valid ? md_load_of(e_md_op) : MD_LD_NONE;
      stall    = !reset && md_is_md(d_md_op) && ((state_q != ST_IDLE) || issue);

      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (issue) state_d = ST_BUSY;
         ST_BUSY:  if (cnt_is_one) state_d = md_busy ? ST_DRAIN : ST_IDLE;
         ST_DRAIN: if (!md_busy) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Unit went idle too early, or an op that needs the unit reached E while it was busy.
      err_d = err_q;
      if ((state_q == ST_BUSY) && !md_busy && (cnt > 4'd1)) err_d = 1'b1;
      if ((state_q != ST_IDLE) && (e_start || e_mt))        err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   md_lat_counter u_lat_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (issue),
      .load_val (md_is_div(e_md_op) ? DIV_LOAD : MULT_LOAD),
      .dec      (state_q == ST_BUSY),
      .cnt      (cnt),
      .is_one   (cnt_is_one)
   );

   assign md_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
//==============================================================================
// tb_md_issue_ctrl : directed scenarios plus randomized run against a
// cycle-timestamp reference model of the issue controller
//==============================================================================
`default_nettype none

module tb_md_issue_ctrl;
   import md_pkg::*;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] d_md_op, e_md_op;
   logic       e_valid, md_busy;
   logic       md_start, md_u, stall, md_err;
   logic [2:0] md_sel;
   logic [1:0] md_write, md_load;

   int asserts = 0;
   int fails   = 0;

   md_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .reset(reset), .d_md_op(d_md_op), .e_md_op(e_md_op),
      .e_valid(e_valid), .md_busy(md_busy), .md_start(md_start), .md_sel(md_sel),
      .md_u(md_u), .md_write(md_write), .md_load(md_load), .stall(stall), .md_err(md_err)
   );

   always #5 clk = ~clk;

   // Reference classification written directly from the op table
   function automatic bit m_start(input logic [3:0] op);
      case (op)
         4'd1, 4'd2, 4'd3, 4'd4: return 1'b1;
`ifdef MD_MADD_EN
         4'd5, 4'd6, 4'd7, 4'd8: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit m_md(input logic [3:0] op);
      return m_start(op) || (op >= 4'd9 && op <= 4'd12);
   endfunction

   function automatic logic [2:0] m_sel(input logic [3:0] op);
      case (op)
         4'd1, 4'd2: return 3'd1;
         4'd3, 4'd4: return 3'd2;
         4'd5, 4'd6: return 3'd3;
         4'd7, 4'd8: return 3'd4;
         default:    return 3'd0;
      endcase
   endfunction

   function automatic bit m_u(input logic [3:0] op);
      return (op == 4'd2) || (op == 4'd4) || (op == 4'd6) || (op == 4'd8);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [3:0] dop, input logic ev,
                        input logic [3:0] eop, input logic mb);
      reset = r; d_md_op = dop; e_valid = ev; e_md_op = eop; md_busy = mb;
   endtask

   task automatic test_reset();
      drive(1'b1, MD_MFLO, 1'b1, MD_MULT, 1'b0);
      tick(); tick();
      #3;
      asserts++; if (md_start !== 1'b0) begin fails++; $display("FAIL reset_start: got %0b want 0", md_start); end
      asserts++; if (md_sel !== 3'd0) begin fails++; $display("FAIL reset_sel: got %0d want 0", md_sel); end
      asserts++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b want 0", stall); end
      asserts++; if (md_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b want 0", md_err); end
      tick();
      drive(1'b1, MD_NONE, 1'b1, MD_MTHI, 1'b0);
      #3;
      asserts++; if (md_write !== 2'd0) begin fails++; $display("FAIL reset_write: got %0d want 0", md_write); end
      tick();
      drive(1'b0, MD_NONE, 1'b0, MD_NONE, 1'b0);
      tick();
   endtask

   task automatic test_mult();
      for (int c = 0; c <= 10; c++) begin
         drive(1'b0, (c == 10) ? MD_MFLO : ((c > 0 && c <= 5) ? MD_MFHI : MD_NONE),
               (c == 0 || c == 5), MD_MULT,
               (c >= 1 && c <= MULT_LAT - 2) || (c >= 6 && c <= 5 + MULT_LAT - 2));
         #3;
         if (c == 0) begin
            asserts++; if (md_start !== 1'b1 || md_sel !== 3'd1 || md_u !== 1'b0) begin
               fails++; $display("FAIL mult_issue: start=%0b sel=%0d u=%0b want 1/1/0", md_start, md_sel, md_u); end
         end else if (c <= 4) begin
            asserts++; if (stall !== 1'b1) begin fails++; $display("FAIL mult_busy_stall c%0d: got %0b want 1", c, stall); end
         end else if (c == 5) begin
            asserts++; if (md_start !== 1'b1 || stall !== 1'b1) begin
               fails++; $display("FAIL mult_back_to_back: start=%0b stall=%0b want 1/1", md_start, stall); end
         end else if (c == 10) begin
            asserts++; if (stall !== 1'b0) begin fails++; $display("FAIL mult_idle_stall: got %0b want 0", stall); end
         end
         tick();
      end
   endtask

   task automatic test_divu_mflo();
      for (int c = 0; c <= 11; c++) begin
         drive(1'b0, (c >= 1 && c <= 10) ? MD_MFLO : MD_NONE, (c == 0 || c == 11),
               (c == 0) ? MD_DIVU : MD_MFLO, (c >= 1 && c <= DIV_LAT - 2));
         #3;
         if (c == 0) begin
            asserts++; if (md_start !== 1'b1 || md_sel !== 3'd2 || md_u !== 1'b1) begin
               fails++; $display("FAIL divu_issue: start=%0b sel=%0d u=%0b want 1/2/1", md_start, md_sel, md_u); end
         end else if (c <= 9) begin
            asserts++; if (stall !== 1'b1) begin fails++; $display("FAIL divu_stall c%0d: got %0b want 1", c, stall); end
         end else if (c == 10) begin
            asserts++; if (stall !== 1'b0) begin fails++; $display("FAIL divu_release: got %0b want 0", stall); end
         end else begin
            asserts++; if (md_load !== 2'd2 || md_write !== 2'd0) begin
               fails++; $display("FAIL mflo_load: load=%0d write=%0d want 2/0", md_load, md_write); end
         end
         tick();
      end
   endtask

   task automatic test_drain();
      for (int c = 0; c <= 7; c++) begin
         drive(1'b0, (c >= 1) ? MD_MFHI : MD_NONE, (c == 0), MD_MULT, (c >= 1 && c <= MULT_LAT));
         #3;
         if (c >= 1 && c <= 6) begin
            asserts++; if (stall !== 1'b1) begin fails++; $display("FAIL drain_stall c%0d: got %0b want 1", c, stall); end
         end else if (c == 7) begin
            asserts++; if (stall !== 1'b0 || md_err !== 1'b0) begin
               fails++; $display("FAIL drain_exit: stall=%0b err=%0b want 0/0", stall, md_err); end
         end
         tick();
      end
   endtask

   task automatic test_div_err();
      for (int c = 0; c <= 10; c++) begin
         drive(c == 10, MD_NONE, (c == 0), MD_DIV, (c >= 1 && c <= 2));
         #3;
         if (c == 3) begin
            asserts++; if (md_err !== 1'b0) begin fails++; $display("FAIL div_err_early: got %0b want 0", md_err); end
         end else if (c >= 4 && c <= 10) begin
            asserts++; if (md_err !== 1'b1) begin fails++; $display("FAIL div_err_sticky c%0d: got %0b want 1", c, md_err); end
         end
         tick();
      end
      drive(1'b0, MD_NONE, 1'b0, MD_NONE, 1'b0);
      #3;
      asserts++; if (md_err !== 1'b0) begin fails++; $display("FAIL div_err_clear: got %0b want 0", md_err); end
      tick();
   endtask

   task automatic test_reset_inflight();
      for (int c = 0; c <= 10; c++) begin
         drive(c == 4, (c == 4 || c == 10) ? MD_MFLO : MD_NONE, (c == 0 || c == 5),
               (c == 0) ? MD_DIV : MD_MULT, (c >= 1 && c <= 3) || (c >= 6 && c <= 8));
         #3;
         if (c == 4) begin
            asserts++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_inflight_stall: got %0b want 0", stall); end
         end else if (c == 5) begin
            asserts++; if (md_start !== 1'b1 || md_sel !== 3'd1) begin
               fails++; $display("FAIL rst_then_mult: start=%0b sel=%0d want 1/1", md_start, md_sel); end
         end else if (c == 10) begin
            asserts++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_mult_done: got %0b want 0", stall); end
         end
         tick();
      end
   endtask

   task automatic test_mt();
      for (int c = 0; c <= 8; c++) begin
         case (c)
            0: drive(1'b0, MD_NONE, 1'b1, MD_MTHI,  1'b0);
            1: drive(1'b0, MD_NONE, 1'b1, MD_MTLO,  1'b0);
            2: drive(1'b0, MD_NONE, 1'b1, MD_MULTU, 1'b0);
            3: drive(1'b0, MD_NONE, 1'b1, MD_MTLO,  1'b1);
            4: drive(1'b0, MD_NONE, 1'b1, MD_MFHI,  1'b1);
            5: drive(1'b0, MD_NONE, 1'b0, MD_NONE,  1'b1);
            7: drive(1'b1, MD_NONE, 1'b0, MD_NONE,  1'b0);
            default: drive(1'b0, MD_NONE, 1'b0, MD_NONE, 1'b0);
         endcase
         #3;
         if (c == 0) begin
            asserts++; if (md_write !== 2'd1) begin fails++; $display("FAIL mthi_write: got %0d want 1", md_write); end
         end else if (c == 1) begin
            asserts++; if (md_write !== 2'd2) begin fails++; $display("FAIL mtlo_write: got %0d want 2", md_write); end
         end else if (c == 2) begin
            asserts++; if (md_start !== 1'b1 || md_u !== 1'b1 || md_sel !== 3'd1) begin
               fails++; $display("FAIL multu_issue: start=%0b sel=%0d u=%0b want 1/1/1", md_start, md_sel, md_u); end
         end else if (c == 3) begin
            asserts++; if (md_write !== 2'd0) begin fails++; $display("FAIL mt_in_busy: write=%0d want 0", md_write); end
         end else if (c == 4) begin
            asserts++; if (md_err !== 1'b1 || md_load !== 2'd1) begin
               fails++; $display("FAIL mt_err_mf_load: err=%0b load=%0d want 1/1", md_err, md_load); end
         end else if (c == 8) begin
            asserts++; if (md_err !== 1'b0) begin fails++; $display("FAIL mt_err_reset: got %0b want 0", md_err); end
         end
         tick();
      end
   endtask

   task automatic test_madd();
`ifdef MD_MADD_EN
      for (int c = 0; c <= 10; c++) begin
         drive(1'b0, (c == 0) ? MD_MADD : ((c <= 5) ? MD_MFLO : MD_NONE), (c == 0 || c == 5),
               (c == 0) ? MD_MADD : MD_MSUBU, (c >= 1 && c <= 3) || (c >= 6 && c <= 8));
         #3;
         if (c == 0) begin
            asserts++; if (md_start !== 1'b1 || md_sel !== 3'd3 || stall !== 1'b1) begin
               fails++; $display("FAIL madd_issue: start=%0b sel=%0d stall=%0b want 1/3/1", md_start, md_sel, stall); end
         end else if (c <= 4) begin
            asserts++; if (stall !== 1'b1) begin fails++; $display("FAIL madd_busy c%0d: got %0b want 1", c, stall); end
         end else if (c == 5) begin
            asserts++; if (md_start !== 1'b1 || md_sel !== 3'd4 || md_u !== 1'b1) begin
               fails++; $display("FAIL msubu_issue: start=%0b sel=%0d u=%0b want 1/4/1", md_start, md_sel, md_u); end
         end
         tick();
      end
`else
      for (int c = 0; c <= 6; c++) begin
         drive(1'b0, (c == 2) ? MD_MSUB : MD_MADD, (c <= 1), (c == 0) ? MD_MADD : MD_MULT,
               (c >= 2 && c <= 4));
         #3;
         if (c == 0) begin
            asserts++; if (md_start !== 1'b0 || md_sel !== 3'd0 || stall !== 1'b0) begin
               fails++; $display("FAIL madd_disabled: start=%0b sel=%0d stall=%0b want 0/0/0", md_start, md_sel, stall); end
         end else if (c == 1) begin
            asserts++; if (md_start !== 1'b1 || stall !== 1'b0) begin
               fails++; $display("FAIL madd_d_with_issue: start=%0b stall=%0b want 1/0", md_start, stall); end
         end else if (c == 2) begin
            asserts++; if (stall !== 1'b0) begin fails++; $display("FAIL msub_d_in_busy: got %0b want 0", stall); end
         end
         tick();
      end
`endif
   endtask

   // Model tracks the issue time-stamp and the cycle of the last counted busy cycle.
   task automatic test_random();
      int  cyc = 0;
      bit  active = 0, draining = 0, err = 0;
      int  busy_end = -1, unit_end = -1;
      bit  r, ev, mb, x_start, x_u, x_stall, idle;
      logic [3:0] eop, dop;
      logic [2:0] x_sel;
      logic [1:0] x_write, x_load;
      int  lat;

      drive(1'b1, MD_NONE, 1'b0, MD_NONE, 1'b0);
      tick();
      for (int n = 0; n < 3000; n++) begin
         r   = ($urandom_range(0, 99) == 0);
         ev  = $urandom_range(0, 1);
         eop = 4'($urandom_range(0, 15));
         dop = 4'($urandom_range(0, 15));
         if (active && $urandom_range(0, 9) != 0) ev = 0;
         mb  = (cyc <= unit_end);
         if ($urandom_range(0, 49) == 0) mb = ~mb;
         drive(r, dop, ev, eop, mb);

         idle    = !active;
         x_start = !r && ev && m_start(eop) && idle;
         x_sel   = x_start ? m_sel(eop) : 3'd0;
         x_u     = x_start && m_u(eop);
         x_write = (!r && ev && idle) ? ((eop == 4'd9) ? 2'd1 : (eop == 4'd10) ? 2'd2 : 2'd0) : 2'd0;
         x_load  = ev ? ((eop == 4'd11) ? 2'd1 : (eop == 4'd12) ? 2'd2 : 2'd0) : 2'd0;
         x_stall = !r && m_md(dop) && (!idle || x_start);
         #3;
         asserts++; if (md_start !== x_start) begin fails++; $display("FAIL rnd_start n%0d: got %0b want %0b", n, md_start, x_start); end
         asserts++; if (md_sel !== x_sel) begin fails++; $display("FAIL rnd_sel n%0d: got %0d want %0d", n, md_sel, x_sel); end
         asserts++; if (md_u !== x_u) begin fails++; $display("FAIL rnd_u n%0d: got %0b want %0b", n, md_u, x_u); end
         asserts++; if (md_write !== x_write) begin fails++; $display("FAIL rnd_write n%0d: got %0d want %0d", n, md_write, x_write); end
         asserts++; if (md_load !== x_load) begin fails++; $display("FAIL rnd_load n%0d: got %0d want %0d", n, md_load, x_load); end
         asserts++; if (stall !== x_stall) begin fails++; $display("FAIL rnd_stall n%0d: got %0b want %0b", n, stall, x_stall); end
         asserts++; if (md_err !== err) begin fails++; $display("FAIL rnd_err n%0d: got %0b want %0b", n, md_err, err); end

         if (r) begin
            active = 0; draining = 0; err = 0; busy_end = -1; unit_end = -1;
         end else begin
            if (active && ev && (m_start(eop) || eop == 4'd9 || eop == 4'd10)) err = 1;
            if (x_start) begin
               lat      = (eop == 4'd3 || eop == 4'd4) ? DIV_LAT : MULT_LAT;
               active   = 1; draining = 0;
               busy_end = cyc + lat - 1;
               unit_end = cyc + lat - 2 + (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
            end else if (active && !draining) begin
               if (cyc == busy_end) begin
                  if (mb) draining = 1; else active = 0;
               end else if (!mb) begin
                  err = 1;
               end
            end else if (draining && !mb) begin
               active = 0; draining = 0;
            end
         end
         tick();
         cyc++;
      end
      drive(1'b1, MD_NONE, 1'b0, MD_NONE, 1'b0);
      tick();
      drive(1'b0, MD_NONE, 1'b0, MD_NONE, 1'b0);
   endtask

   initial begin
      drive(1'b1, MD_NONE, 1'b0, MD_NONE, 1'b0);
      test_reset();
      test_mult();
      test_divu_mflo();
      test_drain();
      test_div_err();
      test_reset_inflight();
      test_mt();
      test_madd();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule

`default_nettype wire
